// File: rtl/card_pkg.sv
// Shared types and defaults for the card shoe datapath.
package card_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  localparam int unsigned NUM_RANKS_DEF = 13;
  localparam int unsigned SUITS_DEF     = 4;
  localparam int unsigned CARD_NONE     = 0;

endpackage

// File: rtl/rank_ptr.sv
// Free-running rank pointer: counts 1..NUM_RANKS and wraps back to 1.
module rank_ptr #(
  parameter int unsigned NUM_RANKS = 13,
  parameter int unsigned PTR_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic [PTR_W-1:0] ptr
);

  // Advance every clock; the timing of requests against this is the randomness source.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= PTR_W'(1);
    end else if (ptr == PTR_W'(NUM_RANKS)) begin
      ptr <= PTR_W'(1);
    end else begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/card_shoe.sv
// Multi-deck card shoe: per-rank counts, one card per accepted request,
// exhausted ranks skipped by a linear scan starting at the rank pointer.
module card_shoe
  import card_pkg::*;
#(
  parameter int unsigned NUM_DECKS = 1,
  parameter int unsigned NUM_RANKS = NUM_RANKS_DEF,
  parameter int unsigned SUITS     = SUITS_DEF,
  parameter int unsigned CARD_W    = 4,
  localparam int unsigned PER_RANK = SUITS * NUM_DECKS,
  localparam int unsigned TOTAL    = NUM_RANKS * PER_RANK,
  localparam int unsigned RC_W     = $clog2(PER_RANK + 1),
  localparam int unsigned CNT_W    = $clog2(TOTAL + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              deal_req,
  input  logic              shuffle,
  output logic              ready,
  output logic              card_valid,
  output logic [CARD_W-1:0] new_card,
  output logic              deal_err,
  output logic [CNT_W-1:0]  cards_left,
  output logic              shoe_empty
);

  localparam int unsigned IDX_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  state_t            state;
  logic [CARD_W-1:0] ptr;
  logic [CARD_W-1:0] scan_idx;
  logic [RC_W-1:0]   rank_cnt [NUM_RANKS];
  logic [IDX_W-1:0]  scan_pos_c;
  logic              hit_c;

  rank_ptr #(
    .NUM_RANKS (NUM_RANKS),
    .PTR_W     (CARD_W)
  ) u_rank_ptr (
    .clock (clock),
    .reset (reset),
    .ptr   (ptr)
  );

  // Card codes are 1-based; the count array is 0-based.
  assign scan_pos_c = IDX_W'(scan_idx - CARD_W'(1));
  assign hit_c      = (rank_cnt[scan_pos_c] != '0);

  // Status flags decoded straight from registered state.
  assign shoe_empty = (cards_left == '0);
  assign ready      = (state == IDLE);

  // Deal / restock state machine with registered card outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      scan_idx   <= CARD_W'(1);
      cards_left <= CNT_W'(TOTAL);
      new_card   <= CARD_W'(CARD_NONE);
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_RANKS; i++) begin
        rank_cnt[i] <= RC_W'(PER_RANK);
      end
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (shuffle) begin
            // Restock wins over a same-cycle request.
            cards_left <= CNT_W'(TOTAL);
            for (int unsigned i = 0; i < NUM_RANKS; i++) begin
              rank_cnt[i] <= RC_W'(PER_RANK);
            end
          end else if (deal_req && shoe_empty) begin
            deal_err <= 1'b1;
          end else if (deal_req) begin
            scan_idx <= ptr;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          // Entry requires a non-empty shoe, so this always finds a card.
          if (hit_c) begin
            rank_cnt[scan_pos_c] <= rank_cnt[scan_pos_c] - RC_W'(1);
            cards_left           <= cards_left - CNT_W'(1);
            new_card             <= scan_idx;
            card_valid           <= 1'b1;
            state                <= IDLE;
          end else if (scan_idx == CARD_W'(NUM_RANKS)) begin
            scan_idx <= CARD_W'(1);
          end else begin
            scan_idx <= scan_idx + CARD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
